// File: rtl/load_unit.sv
// rtl/load_unit.sv - RISC-V load unit: address check, single word read, byte/half/word extraction
module load_unit #(
    parameter int TAG_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_imm,
    input  logic [2:0]       in_funct3,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [31:0]      mem_req_addr,
    input  logic             mem_resp_valid,
    input  logic [31:0]      mem_resp_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_fault
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t             state, state_nxt;
    logic [31:0]        ea_q;
    logic [2:0]         funct3_q;
    logic [TAG_W-1:0]   tag_q;
    logic [31:0]        data_q;
    logic               fault_q;

    logic [31:0]        ea_in;
    logic               illegal_in, misaligned_in, fault_in;
    logic               accept, capture;
    logic [31:0]        shifted;
    logic [31:0]        ext_data;

    assign ea_in         = in_rs1 + in_imm;
    assign illegal_in    = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
    assign misaligned_in = ((in_funct3[1:0] == 2'b01) && ea_in[0]) ||
                           ((in_funct3[1:0] == 2'b10) && (ea_in[1:0] != 2'b00));
    assign fault_in      = illegal_in || misaligned_in;

    assign accept  = (state == S_IDLE) && in_valid && !flush;
    assign capture = (state == S_WAIT) && mem_resp_valid && !flush;

    // Byte/half lanes are brought down to bit 0 by the byte offset; halves are aligned here.
    assign shifted = mem_resp_data >> {ea_q[1:0], 3'b000};

    always_comb begin
        ext_data = mem_resp_data;
        case (funct3_q)
            3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext_data = {24'd0, shifted[7:0]};
            3'b101:  ext_data = {16'd0, shifted[15:0]};
            default: ext_data = mem_resp_data;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_nxt = fault_in ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (flush) begin
                    // A request accepted in the flush cycle still owes us a response.
                    state_nxt = mem_req_ready ? S_DRAIN : S_IDLE;
                end else if (mem_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_nxt = mem_resp_valid ? S_IDLE : S_DRAIN;
                end else if (mem_resp_valid) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mem_resp_valid) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ea_q     <= 32'd0;
            funct3_q <= 3'd0;
            tag_q    <= '0;
            data_q   <= 32'd0;
            fault_q  <= 1'b0;
        end else begin
            if (accept) begin
                ea_q     <= ea_in;
                funct3_q <= in_funct3;
                tag_q    <= in_tag;
                fault_q  <= fault_in;
                data_q   <= 32'd0;
            end
            if (capture) begin
                data_q <= ext_data;
            end
        end
    end

    assign mem_req_addr = {ea_q[31:2], 2'b00};
    assign out_data     = data_q;
    assign out_tag      = tag_q;
    assign out_fault    = fault_q;

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - self-checking bench for load_unit with directed and randomized loads
module tb_load_unit;
    localparam int TAG_W = 6;

    logic             clock = 1'b0;
    logic             reset, flush, in_valid, in_ready;
    logic [31:0]      in_rs1, in_imm;
    logic [2:0]       in_funct3;
    logic [TAG_W-1:0] in_tag;
    logic             mem_req_valid, mem_req_ready;
    logic [31:0]      mem_req_addr;
    logic             mem_resp_valid;
    logic [31:0]      mem_resp_data;
    logic             out_valid, out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_fault;

    int checks = 0;
    int failures = 0;

    load_unit #(.TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_rs1(in_rs1), .in_imm(in_imm),
        .in_funct3(in_funct3), .in_tag(in_tag),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_fault(out_fault)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic bit model_fault(input logic [2:0] f3, input logic [31:0] ea);
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (ea % 2) != 0;
            3'd2:       return (ea % 4) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_data(input logic [2:0] f3, input logic [31:0] ea,
                                               input logic [31:0] word);
        int unsigned off;
        logic [31:0] v;
        off = ea % 4;
        case (f3)
            3'd0, 3'd4: begin
                v = (word >> (8 * off)) & 32'h0000_00FF;
                if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (word >> (16 * (off / 2))) & 32'h0000_FFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    task automatic chk_idle(input string name);
        chk({name, "_in_ready"}, in_ready, 1);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_mem_req_valid"}, mem_req_valid, 0);
    endtask

    task automatic present(input logic [31:0] rs1, input logic [31:0] imm, input logic [2:0] f3,
                           input logic [TAG_W-1:0] tag);
        in_valid = 1'b1; in_rs1 = rs1; in_imm = imm; in_funct3 = f3; in_tag = tag;
        step();
        in_valid = 1'b0; in_rs1 = $urandom; in_imm = $urandom; in_funct3 = 3'($urandom); in_tag = '0;
    endtask

    task automatic do_load(input string name, input logic [31:0] rs1, input logic [31:0] imm,
                           input logic [2:0] f3, input logic [TAG_W-1:0] tag,
                           input int req_stall, input int resp_delay, input int out_stall,
                           input logic [31:0] word);
        logic [31:0] ea, exp_data;
        bit flt;
        ea = rs1 + imm;
        flt = model_fault(f3, ea);
        exp_data = flt ? 32'd0 : model_data(f3, ea, word);
        present(rs1, imm, f3, tag);
        chk({name, "_in_ready_busy"}, in_ready, 0);
        if (flt) begin
            chk({name, "_no_req"}, mem_req_valid, 0);
        end else begin
            chk({name, "_req_valid"}, mem_req_valid, 1);
            chk({name, "_req_addr"}, mem_req_addr, {ea[31:2], 2'b00});
            repeat (req_stall) begin
                step();
                chk({name, "_req_hold"}, mem_req_valid, 1);
                chk({name, "_req_addr_hold"}, mem_req_addr, {ea[31:2], 2'b00});
                chk({name, "_in_ready_req"}, in_ready, 0);
            end
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
            chk({name, "_wait_req"}, mem_req_valid, 0);
            chk({name, "_wait_out"}, out_valid, 0);
            repeat (resp_delay) begin
                step();
                chk({name, "_wait_out"}, out_valid, 0);
            end
            mem_resp_valid = 1'b1; mem_resp_data = word;
            step();
            mem_resp_valid = 1'b0; mem_resp_data = $urandom;
        end
        chk({name, "_out_valid"}, out_valid, 1);
        chk({name, "_out_data"}, out_data, exp_data);
        chk({name, "_out_tag"}, 32'(out_tag), 32'(tag));
        chk({name, "_out_fault"}, out_fault, flt);
        repeat (out_stall) begin
            step();
            chk({name, "_out_hold"}, out_valid, 1);
            chk({name, "_out_data_hold"}, out_data, exp_data);
            chk({name, "_out_tag_hold"}, 32'(out_tag), 32'(tag));
            chk({name, "_in_ready_done"}, in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_idle({name, "_after"});
    endtask

    initial begin
        logic [31:0] rs1, imm;
        logic [2:0]  f3;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_imm = '0; in_funct3 = '0;
        in_tag = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        chk_idle("reset");
        chk("reset_out_data", out_data, 0);
        chk("reset_out_tag", 32'(out_tag), 0);
        chk("reset_out_fault", out_fault, 0);

        do_load("lw_basic", 32'h1000, 32'd4, 3'b010, 6'd5, 0, 0, 0, 32'hDEADBEEF);
        do_load("lb_neg", 32'h1000, 32'd3, 3'b000, 6'd1, 0, 0, 0, 32'h80FF7F01);
        chk("lb_neg_const", out_data, 32'hFFFFFF80);
        do_load("lbu", 32'h1000, 32'd3, 3'b100, 6'd2, 0, 0, 0, 32'h80FF7F01);
        do_load("lh_neg", 32'h1000, 32'd2, 3'b001, 6'd3, 0, 0, 0, 32'h80FF7F01);
        do_load("lh_mis", 32'h1000, 32'd1, 3'b001, 6'd4, 0, 0, 0, 32'h0);
        do_load("f3_ill", 32'h1000, 32'd0, 3'b011, 6'd6, 0, 0, 0, 32'h0);
        do_load("stalls", 32'h1FF0, 32'h10, 3'b010, 6'd7, 3, 1, 2, 32'h12345678);

        // Flush in WAIT, response arrives two cycles later and must be dropped.
        present(32'h3000, 32'd0, 3'b010, 6'd9);
        mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
        flush = 1'b1; step(); flush = 1'b0;
        chk("fw_drain_in_ready", in_ready, 0);
        chk("fw_drain_out", out_valid, 0);
        step();
        chk("fw_drain_in_ready2", in_ready, 0);
        mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0BAD0; step(); mem_resp_valid = 1'b0;
        chk_idle("fw_after_resp");
        do_load("post_flush", 32'h2000, 32'd0, 3'b010, 6'd10, 0, 0, 0, 32'hCAFEF00D);

        // Flush in REQ without handshake returns straight to IDLE.
        present(32'h4000, 32'd0, 3'b010, 6'd11);
        flush = 1'b1; step(); flush = 1'b0;
        chk_idle("fr_noready");

        // Flush in REQ with handshake drains; a flush during DRAIN changes nothing.
        present(32'h4000, 32'd0, 3'b010, 6'd12);
        flush = 1'b1; mem_req_ready = 1'b1; step(); flush = 1'b0; mem_req_ready = 1'b0;
        chk("fr_ready_drain", in_ready, 0);
        chk("fr_ready_noreq", mem_req_valid, 0);
        flush = 1'b1; step(); flush = 1'b0;
        chk("fr_drain_flush", in_ready, 0);
        mem_resp_valid = 1'b1; step(); mem_resp_valid = 1'b0;
        chk_idle("fr_ready_done");

        // Flush in WAIT coinciding with the response drops the data immediately.
        present(32'h5000, 32'd0, 3'b010, 6'd13);
        mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
        flush = 1'b1; mem_resp_valid = 1'b1; step(); flush = 1'b0; mem_resp_valid = 1'b0;
        chk_idle("fw_resp");

        // Flush in DONE, and flush in IDLE with a load offered.
        present(32'h5000, 32'd1, 3'b010, 6'd14);
        chk("fd_done", out_valid, 1);
        flush = 1'b1; out_ready = 1'b1; step(); flush = 1'b0; out_ready = 1'b0;
        chk_idle("fd_flush");
        flush = 1'b1; in_valid = 1'b1; in_rs1 = 32'h6000; in_imm = 0; in_funct3 = 3'b010;
        step(); flush = 1'b0; in_valid = 1'b0;
        chk_idle("fi_flush");

        // Reset in WAIT and in DONE.
        present(32'h7000, 32'd0, 3'b010, 6'd15);
        mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        chk_idle("rst_wait");
        present(32'h7000, 32'd2, 3'b010, 6'd16);
        reset = 1'b1; step(); reset = 1'b0;
        chk_idle("rst_done");
        do_load("post_reset", 32'h7000, 32'd6, 3'b101, 6'd17, 0, 0, 0, 32'h9ABC1234);

        for (int i = 0; i < 40; i++) begin
            rs1 = $urandom;
            imm = 32'($urandom_range(0, 255)) - 32'd128;
            if ($urandom_range(0, 1) == 1) begin
                rs1 = rs1 & 32'hFFFF_FFFC;
                imm = imm & 32'hFFFF_FFFC;
                rs1 = rs1 + 32'($urandom_range(0, 3) & ($urandom_range(0, 1) ? 2 : 0));
            end
            f3 = 3'($urandom_range(0, 7));
            do_load("rand", rs1, imm, f3, 6'($urandom), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
